dif_radix2_64p_da_ctrl: RTL

Sequencer for the 64-point radix-2 DIF data arranger (8 register banks × 8 entries).
- Accepts one 64-sample frame in natural order through a valid/ready handshake and drives the arranger write controls.
- Then issues 64 reads in a selectable permuted order (natural, 8×8 transpose, or 6-bit bit-reverse).
- Tags the arranger output stream with valid/first/last/index aligned to the arranger's read latency.
- Sits between an FFT stage output and the next stage or output reorder.

---
 rtl/dif_radix2_64p_pkg.sv | 40 ++++
 rtl/dif_radix2_64p_dly.sv | 31 +++
 rtl/dif_radix2_64p_da_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/dif_radix2_64p_pkg.sv
// Shared constants, types and the read-order permutation for the 64-point
// radix-2 DIF data-arranger sequencer.
package dif_radix2_64p_pkg;

    localparam logic [1:0] ORD_NAT   = 2'd0;
    localparam logic [1:0] ORD_TRANS = 2'd1;
    localparam logic [1:0] ORD_BREV  = 2'd2;

    localparam logic [3:0] CTRL_OFF = 4'b1000;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    typedef struct packed {
        logic       valid;
        logic       first;
        logic       last;
        logic [5:0] index;
    } meta_t;

    // Source index n for output position k under the selected read order.
    function automatic logic [5:0] perm6(input logic [1:0] order, input logic [5:0] k);
        logic [5:0] r;
        r = k;
        case (order)
            ORD_NAT:   r = k;
            ORD_TRANS: r = {k[2:0], k[5:3]};
            ORD_BREV: begin
                for (int i = 0; i < 6; i++) begin
                    r[i] = k[5-i];
                end
            end
            default:   r = k;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dif_radix2_64p_dly.sv
// Fixed-depth register delay line with synchronous active-low clear; carries
// read metadata alongside the arranger's read latency.
module dif_radix2_64p_dly #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_r [DEPTH];

    // Shift register; clear flushes every stage so nothing in flight survives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            pipe_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign dout = pipe_r[DEPTH-1];

endmodule

// File: rtl/dif_radix2_64p_da_ctrl.sv
// Fill/drain sequencer for the 8x8 DIF data arranger: natural-order writes,
// permuted reads, and latency-aligned output tagging.
module dif_radix2_64p_da_ctrl
    import dif_radix2_64p_pkg::*;
#(
    parameter int         RD_LAT = 1,
    parameter logic [1:0] ORDER  = ORD_TRANS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       out_en,
    output logic [3:0] wen_ctrl,
    output logic [2:0] waddr_ctrl,
    output logic [3:0] ren_ctrl,
    output logic [2:0] raddr_ctrl,
    output logic       out_valid,
    output logic       out_first,
    output logic       out_last,
    output logic [5:0] out_index,
    output logic       frame_done
);

    state_e     state_r, state_s;
    logic [5:0] wcnt_r, wcnt_s;
    logic [5:0] rcnt_r, rcnt_s;
    logic       wfire_s, rfire_s;
    logic [5:0] src_s;
    meta_t      meta_in_s, meta_out_s;

    // Next-state logic and arranger controls; reset low suppresses any access.
    always_comb begin
        state_s    = state_r;
        wcnt_s     = wcnt_r;
        rcnt_s     = rcnt_r;
        in_ready   = 1'b0;
        wfire_s    = 1'b0;
        rfire_s    = 1'b0;
        wen_ctrl   = CTRL_OFF;
        ren_ctrl   = CTRL_OFF;
        frame_done = 1'b0;
        src_s      = perm6(ORDER, rcnt_r);
        waddr_ctrl = wcnt_r[2:0];
        raddr_ctrl = src_s[2:0];
        case (state_r)
            ST_FILL: begin
                in_ready = rst_n;
                wfire_s  = in_valid & rst_n;
                if (wfire_s) begin
                    wen_ctrl = {1'b0, wcnt_r[5:3]};
                    wcnt_s   = wcnt_r + 6'd1;
                    if (wcnt_r == 6'd63) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    wen_ctrl = CTRL_OFF;
                end
            end
            ST_DRAIN: begin
                rfire_s = out_en & rst_n;
                if (rfire_s) begin
                    ren_ctrl = {1'b0, src_s[5:3]};
                    rcnt_s   = rcnt_r + 6'd1;
                    if (rcnt_r == 6'd63) begin
                        frame_done = 1'b1;
                        state_s    = ST_FILL;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end else begin
                    ren_ctrl = CTRL_OFF;
                end
            end
            default: begin
                state_s = ST_FILL;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_FILL;
            wcnt_r  <= 6'd0;
            rcnt_r  <= 6'd0;
        end else begin
            state_r <= state_s;
            wcnt_r  <= wcnt_s;
            rcnt_r  <= rcnt_s;
        end
    end

    // first/last are qualified by the issue so idle FILL cycles never tag a sample.
    assign meta_in_s = {rfire_s,
                        rfire_s & (rcnt_r == 6'd0),
                        rfire_s & (rcnt_r == 6'd63),
                        rcnt_r};

    dif_radix2_64p_dly #(
        .WIDTH ($bits(meta_t)),
        .DEPTH (RD_LAT)
    ) u_meta_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (meta_in_s),
        .dout  (meta_out_s)
    );

    assign out_valid = meta_out_s.valid;
    assign out_first = meta_out_s.first;
    assign out_last  = meta_out_s.last;
    assign out_index = meta_out_s.index;

endmodule
